// File: rtl/alu_acc_ctrl_if.sv
// Bundle of the command, result and adder connections of the accumulator stage.
// slave is the accumulator stage's view; master is the view of the surrounding logic.
interface alu_acc_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_m;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic             add_v;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, add_s, add_c, add_v, res_ready,
    output cmd_ready, add_a, add_b, add_m, res_valid, res_data, res_flags
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, add_s, add_c, add_v, res_ready,
    input  cmd_ready, add_a, add_b, add_m, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Accumulator/sequencer stage around an external add/sub datapath.
// Define ALU_ACC_SAT_EN to clamp ADD/SUB results on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// EXEC  | adder settles from registered operands; acc/flags captured at cycle end
// RESP  | result held on res_data/res_flags until res_ready
module alu_acc_ctrl #(
  parameter int WIDTH = 4
) (
  input logic     clk,
  input logic     rst_n,
  alu_acc_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic             add_m_q;
  logic [3:0]       flags;
  logic             res_valid_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [3:0]       flags_nxt;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.add_a     = acc;
  assign bus.add_b     = opnd;
  assign bus.add_m     = add_m_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc;
  assign bus.res_flags = flags;

  // Flags are {Z,N,C,V}; Z/N always follow the value that lands in acc.
  always_comb begin
    acc_nxt   = acc;
    flags_nxt = flags;
    case (op_q)
      OP_LOAD: begin
        acc_nxt   = opnd;
        flags_nxt = {(opnd == '0), opnd[WIDTH-1], 1'b0, 1'b0};
      end
      OP_CLR: begin
        acc_nxt   = '0;
        flags_nxt = 4'b1000;
      end
      default: begin
        acc_nxt = bus.add_s;
`ifdef ALU_ACC_SAT_EN
        // Clamp direction follows the sign of acc before the operation.
        if (bus.add_v) begin
          acc_nxt = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags_nxt = {(acc_nxt == '0), acc_nxt[WIDTH-1], bus.add_c, bus.add_v};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_LOAD;
      acc         <= '0;
      opnd        <= '0;
      add_m_q     <= 1'b1;
      flags       <= 4'b0000;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            opnd    <= bus.cmd_data;
            add_m_q <= (bus.cmd_op != OP_SUB);
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc         <= acc_nxt;
          flags       <= flags_nxt;
          res_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl with a behavioural 4-bit add/sub adder.
// Expected values are hand-computed; ALU_ACC_SAT_EN selects the clamped expectations.
module tb_alu_acc_ctrl;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  alu_acc_if #(.WIDTH(W)) bus ();

  alu_acc_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Adder: A-B is computed as A + ~B + 1, so carry=1 means no borrow.
  logic [W-1:0] bb;
  logic [W:0]   sum;
  assign bb        = bus.add_m ? bus.add_b : ~bus.add_b;
  assign sum       = {1'b0, bus.add_a} + {1'b0, bb} + {{W{1'b0}}, ~bus.add_m};
  assign bus.add_s = sum[W-1:0];
  assign bus.add_c = sum[W];
  assign bus.add_v = (bus.add_a[W-1] == bb[W-1]) && (sum[W-1] != bus.add_a[W-1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a command at a falling edge, wait for acceptance, then check the EXEC cycle.
  task automatic issue(input string tag, input logic [1:0] op, input logic [3:0] data);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk({tag, "_ready_timeout"}, 8'(bus.cmd_ready), 8'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({tag, "_exec_rv"}, 8'(bus.res_valid), 8'd0);
    chk({tag, "_exec_cr"}, 8'(bus.cmd_ready), 8'd0);
    chk({tag, "_exec_m"},  8'(bus.add_m), 8'(op != 2'b10));
    if (op != 2'b11) chk({tag, "_exec_b"}, 8'(bus.add_b), 8'(data));
  endtask

  task automatic expect_res(input string tag, input logic [3:0] d, input logic [3:0] f);
    @(negedge clk);
    chk({tag, "_rv"},    8'(bus.res_valid), 8'd1);
    chk({tag, "_data"},  8'(bus.res_data), 8'(d));
    chk({tag, "_flags"}, 8'(bus.res_flags), 8'(f));
  endtask

  task automatic take(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_drop_rv"}, 8'(bus.res_valid), 8'd0);
    chk({tag, "_drop_cr"}, 8'(bus.cmd_ready), 8'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] data,
                        input logic [3:0] d, input logic [3:0] f);
    issue(tag, op, data);
    expect_res(tag, d, f);
    take(tag);
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while a result is pending in RESP
    issue("pre", 2'b00, 4'd7);
    expect_res("pre", 4'd7, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("rst_rv",    8'(bus.res_valid), 8'd0);
    chk("rst_data",  8'(bus.res_data), 8'd0);
    chk("rst_flags", 8'(bus.res_flags), 8'd0);
    chk("rst_cr",    8'(bus.cmd_ready), 8'd1);
    chk("rst_m",     8'(bus.add_m), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rv", 8'(bus.res_valid), 8'd0);
    chk("post_rst_cr", 8'(bus.cmd_ready), 8'd1);

    // Add with and without overflow
    run_op("ld3",  2'b00, 4'd3, 4'b0011, 4'b0000);
    run_op("add4", 2'b01, 4'd4, 4'b0111, 4'b0000);
`ifdef ALU_ACC_SAT_EN
    run_op("add1", 2'b01, 4'd1, 4'b0111, 4'b0001);
`else
    run_op("add1", 2'b01, 4'd1, 4'b1000, 4'b0101);
`endif

    // Subtract: zero result, borrow, negative overflow
    run_op("ld5",  2'b00, 4'd5, 4'b0101, 4'b0000);
    run_op("sub5", 2'b10, 4'd5, 4'b0000, 4'b1010);
    run_op("ld2",  2'b00, 4'd2, 4'b0010, 4'b0000);
    run_op("sub3", 2'b10, 4'd3, 4'b1111, 4'b0100);
    run_op("ld8",  2'b00, 4'd8, 4'b1000, 4'b0100);
`ifdef ALU_ACC_SAT_EN
    run_op("sub1", 2'b10, 4'd1, 4'b1000, 4'b0111);
`else
    run_op("sub1", 2'b10, 4'd1, 4'b0111, 4'b0011);
`endif
    run_op("clr",  2'b11, 4'd9, 4'b0000, 4'b1000);

    // Back-pressure: result held for 5 cycles, second command waits
    run_op("ld2b", 2'b00, 4'd2, 4'b0010, 4'b0000);
    issue("add3", 2'b01, 4'd3);
    expect_res("add3", 4'b0101, 4'b0000);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rv",    8'(bus.res_valid), 8'd1);
      chk("hold_data",  8'(bus.res_data), 8'b0101);
      chk("hold_flags", 8'(bus.res_flags), 8'b0000);
      chk("hold_cr",    8'(bus.cmd_ready), 8'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("wait_rv", 8'(bus.res_valid), 8'd0);
    chk("wait_cr", 8'(bus.cmd_ready), 8'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("acc2_cr", 8'(bus.cmd_ready), 8'd0);
    chk("acc2_b",  8'(bus.add_b), 8'd9);
    expect_res("ld9", 4'b1001, 4'b0100);
    take("ld9");
    repeat (3) begin
      @(negedge clk);
      chk("no_dup_rv", 8'(bus.res_valid), 8'd0);
    end

    // Reset during EXEC discards the pending result
    issue("exec_rst", 2'b01, 4'd4);
    rst_n = 1'b0;
    #1;
    chk("xr_rv",   8'(bus.res_valid), 8'd0);
    chk("xr_data", 8'(bus.res_data), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("xr_no_rv", 8'(bus.res_valid), 8'd0);
      chk("xr_acc",   8'(bus.res_data), 8'd0);
    end
    run_op("ld6", 2'b00, 4'd6, 4'b0110, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
